// File: rtl/connection_matrix_if.sv
// Request/response bundle between a requester and the connection matrix.
// The requester holds a request until ready is high; results come back qualified by out_valid.
interface connection_matrix_if #(
  parameter int DATA_WIDTH        = 6,
  parameter int NODE_ADDRESS_SIZE = 4
);
  logic                         chip_select;
  logic [1:0]                   op;
  logic [NODE_ADDRESS_SIZE-1:0] node_A;
  logic [NODE_ADDRESS_SIZE-1:0] node_B;
  logic [DATA_WIDTH-1:0]        IN;
  logic                         clear_all;
  logic                         ready;
  logic [DATA_WIDTH-1:0]        OUT;
  logic                         out_valid;
  logic                         hit;

  modport master (
    output chip_select, op, node_A, node_B, IN, clear_all,
    input  ready, OUT, out_valid, hit
  );

  modport slave (
    input  chip_select, op, node_A, node_B, IN, clear_all,
    output ready, OUT, out_valid, hit
  );
endinterface

// File: rtl/connection_matrix.sv
// Per-node-pair cost table with valid bits: read, write, saturating add, minimum,
// and a one-entry-per-cycle invalidate sweep after reset or on clear_all.
module connection_matrix #(
  parameter int DATA_WIDTH        = 6,
  parameter int NODE_ADDRESS_SIZE = 4,
  parameter bit SYMMETRIC         = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  connection_matrix_if.slave bus
);
  localparam int IDX_W        = 2 * NODE_ADDRESS_SIZE;
  localparam int ARRAY_LENGTH = 1 << IDX_W;
  localparam int ENTRY_W      = DATA_WIDTH + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RMW} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    hit_q, hit_d;
  logic                    out_valid_q, out_valid_d;
  logic                    rd_out_q, rd_out_d;

  // Entry layout: {valid, value}
  logic [ENTRY_W-1:0]      mem [ARRAY_LENGTH];
  logic [ENTRY_W-1:0]      rd_q;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [ENTRY_W-1:0]      mem_wdata;
  logic [IDX_W-1:0]        req_idx;

  generate
    if (SYMMETRIC) begin : g_sym
      assign req_idx = (bus.node_A >= bus.node_B) ? {bus.node_A, bus.node_B}
                                                  : {bus.node_B, bus.node_A};
    end else begin : g_ord
      assign req_idx = {bus.node_A, bus.node_B};
    end
  endgenerate

  // Read-modify-write datapath works on the entry captured when the request was accepted.
  logic                  old_vld;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] add_res;
  logic [DATA_WIDTH-1:0] min_res;
  logic [DATA_WIDTH-1:0] rmw_res;

  assign old_vld = rd_q[DATA_WIDTH];
  assign old_val = old_vld ? rd_q[DATA_WIDTH-1:0] : '0;
  assign sum     = {1'b0, old_val} + {1'b0, opnd_q};
  assign add_res = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
  assign min_res = !old_vld ? opnd_q : ((old_val < opnd_q) ? old_val : opnd_q);
  assign rmw_res = (op_q == OP_ADD) ? add_res : min_res;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    hit_d       = hit_q;
    out_valid_d = 1'b0;
    rd_out_d    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = {1'b1, bus.IN};
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.clear_all) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (bus.chip_select) begin
          if (bus.op == OP_READ) begin
            out_valid_d = 1'b1;
            rd_out_d    = 1'b1;
          end else if (bus.op == OP_WRITE) begin
            mem_we = 1'b1;
          end else begin
            idx_d   = req_idx;
            op_d    = bus.op;
            opnd_d  = bus.IN;
            state_d = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        mem_we      = 1'b1;
        mem_waddr   = idx_q;
        mem_wdata   = {1'b1, rmw_res};
        res_d       = rmw_res;
        hit_d       = old_vld;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      idx_q       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
      rd_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      hit_q       <= hit_d;
      out_valid_q <= out_valid_d;
      rd_out_q    <= rd_out_d;
    end
  end

  // Reset suppresses the write so an in-flight write-back is abandoned.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[req_idx];
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.OUT       = rd_out_q ? (rd_q[DATA_WIDTH] ? rd_q[DATA_WIDTH-1:0] : '0) : res_q;
  assign bus.hit       = rd_out_q ? rd_q[DATA_WIDTH] : hit_q;

endmodule

// File: doc/connection_matrix.md
# connection_matrix

Parametrised symmetric connection table for the algorithm-2 memory set: stores one `DATA_WIDTH` cost per node pair with a per-entry valid bit. Supports plain write plus in-place read-modify-write (saturating add, minimum) and a hardware sweep that invalidates every entry after reset or on request. It replaces the single-mode write/read pair table wherever routing cost accumulation or minimum tracking is needed.

## Interface

Parameters:
- `DATA_WIDTH`, 6, width of each stored value.
- `NODE_ADDRESS_SIZE`, 4, width of each node id.
- `SYMMETRIC`, 1, 1: (A,B) and (B,A) address the same entry; 0: ordered pairs.
- Derived, not overridable: `ARRAY_LENGTH = 1 << (2*NODE_ADDRESS_SIZE)`.

Ports:
- `CLK` in 1: the only clock; all state changes on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `chip_select` in 1: request strobe, sampled only while `ready`=1.
- `op` in 2: 00 read, 01 write, 10 saturating add, 11 minimum.
- `node_A` in NODE_ADDRESS_SIZE: first node id.
- `node_B` in NODE_ADDRESS_SIZE: second node id.
- `IN` in DATA_WIDTH: write data / operand.
- `clear_all` in 1: start an invalidate sweep, sampled only while `ready`=1.
- `ready` out 1: high when a request or `clear_all` is accepted this cycle.
- `OUT` out DATA_WIDTH: registered result of read / add / min.
- `out_valid` out 1: one-cycle pulse qualifying `OUT`.
- `hit` out 1: entry was valid before the operation; qualified by `out_valid`.

## Operation

- Entry index: SYMMETRIC=1 → {max(A,B), min(A,B)}; SYMMETRIC=0 → {node_A, node_B}. A==B is legal.
- Storage: ARRAY_LENGTH × (DATA_WIDTH+1), synchronous read; invalid entries read as value 0.
- FSM states: CLEAR, IDLE, RMW.
- CLEAR: a counter sweeps addresses 0..ARRAY_LENGTH-1, clearing one valid bit per cycle; `ready`=0; then → IDLE.
- IDLE: `ready`=1. On `clear_all`=1 → CLEAR (counter at 0); `clear_all` wins over a simultaneous `chip_select`, and that request is dropped. On `chip_select`=1:
  - read: `OUT`=stored value (0 if invalid), `hit`=valid bit; stay in IDLE.
  - write: store `IN`, set valid; no `out_valid`; stay in IDLE.
  - add / min: latch index, operand and old entry → RMW.
- RMW (one cycle, `ready`=0): compute the new value, write it back, set valid; `OUT`=new value, `hit`=old valid bit; → IDLE.
  - add: new = min(old + IN, 2^DATA_WIDTH−1), using DATA_WIDTH+1-bit internal sum; invalid old = 0.
  - min: new = invalid ? IN : min(old, IN), unsigned compare.
- Requests with `ready`=0 are ignored (no queueing); the requester must hold them until `ready`=1.

## Timing

- Reset (edge with `RST`=1): `OUT`=0, `out_valid`=0, `hit`=0, `ready`=0, state CLEAR, sweep counter 0. Storage contents are not reset directly; the sweep invalidates them.
- After `RST` deasserts, the sweep takes exactly ARRAY_LENGTH cycles (256 at defaults). `ready` goes high in the cycle after the last address is cleared.
- Read accepted at edge k → `OUT`/`hit` valid and `out_valid`=1 for the cycle after edge k only.
- Write accepted at edge k → data visible to a read accepted at edge k+1 (no hazard).
- Add/min accepted at edge k → write-back and `OUT` at edge k+1; `out_valid`=1 for the cycle after k+1; `ready`=0 between k and k+1; next request accepted at k+1 sees the new value.
- `clear_all` accepted at edge k → `ready`=0 from k; sweep completes ARRAY_LENGTH cycles later.
- `RST` during RMW or CLEAR: a pending write-back is aborted and the sweep restarts from address 0.
- `out_valid` is never high in consecutive cycles for the same request; it is 0 throughout CLEAR.

## Test plan

- Reset, then count the cycles until `ready`=1 → exactly 256; `OUT`=0, `out_valid`=0 throughout.
- Write 42 at (A=12, B=10), then read (A=10, B=12) → `OUT`=42, `hit`=1, `out_valid` for one cycle. With SYMMETRIC=0 the same read → `OUT`=0, `hit`=0.
- Read the never-written pair (3,3) → `OUT`=0, `hit`=0.
- Write 40 at (5,7), then add 30 → `OUT`=63 (saturated), `hit`=1; `ready` low for one cycle. Then read → 63.
- Min 20 on the invalid pair (1,2) → `OUT`=20, `hit`=0. Then min 25 → `OUT`=20; then min 9 → `OUT`=9.
- Write several entries, then assert `clear_all` together with `chip_select` → the request is dropped, 256 cycles pass with `ready`=0, and all prior pairs read `hit`=0. Assert `RST` during an add's RMW cycle → the entry is not updated and the sweep restarts.
